// File: rtl/decode.sv
// decode: RV32I decode stage; splits the fetched word into fields, immediate, ALU code,
// class and trap flags, and registers them for execute under the clk_en/stall/flush protocol.
module decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc,
  input  logic        clk_en,
  output logic [4:0]  rs1_addr_rf,
  output logic [4:0]  rs2_addr_rf,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [31:0] imm,
  output logic [2:0]  funct3,
  output logic [3:0]  alu_op,
  output logic [10:0] opcode_class,
  output logic [31:0] pc,
  output logic        illegal_instr,
  output logic        ecall,
  output logic        ebreak,
  output logic        mret,
  input  logic        stall,
  input  logic        flush,
  output logic        stall_out,
  output logic        flush_out,
  output logic        next_clk_en
);
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLT = 4'd2, SLTU = 4'd3, XOR = 4'd4, OR = 4'd5,
                         AND = 4'd6, SLL = 4'd7, SRL = 4'd8, SRA = 4'd9, EQ = 4'd10, NEQ = 4'd11,
                         GE = 4'd12, GEU = 4'd13;
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic [10:0] cls;
    logic [31:0] pc;
    logic        illegal;
    logic        ecall;
    logic        ebreak;
    logic        mret;
  } dec_t;
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [11:0] i12;
  logic [10:0] cls;
  logic        sys0, alt, bad, trap_ok;
  logic [3:0]  arith_op, br_op;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  dec_t        dec, dec_d, dec_q;
  logic        next_clk_en_d, next_clk_en_q;
  assign op  = fetch_instr[6:0];
  assign f3  = fetch_instr[14:12];
  assign f7  = fetch_instr[31:25];
  assign i12 = fetch_instr[31:20];
  assign cls = {op == 7'b0001111, op == 7'b1110011, op == 7'b0010111, op == 7'b0110111,
                op == 7'b1100111, op == 7'b1101111, op == 7'b1100011, op == 7'b0100011,
                op == 7'b0000011, op == 7'b0010011, op == 7'b0110011};
  assign sys0    = cls[9] && f3 == 3'b000;
  assign alt     = f7 == 7'h20;
  assign trap_ok = sys0 && fetch_instr[19:15] == 5'd0 && fetch_instr[11:7] == 5'd0;
  assign imm_i = {{20{fetch_instr[31]}}, fetch_instr[31:20]};
  assign imm_s = {{20{fetch_instr[31]}}, fetch_instr[31:25], fetch_instr[11:7]};
  assign imm_b = {{19{fetch_instr[31]}}, fetch_instr[31], fetch_instr[7], fetch_instr[30:25],
                  fetch_instr[11:8], 1'b0};
  assign imm_u = {fetch_instr[31:12], 12'b0};
  assign imm_j = {{11{fetch_instr[31]}}, fetch_instr[31], fetch_instr[19:12], fetch_instr[20],
                  fetch_instr[30:21], 1'b0};
  // Unknown opcodes leave cls all-zero, which also covers instr[1:0] != 2'b11.
  assign bad = cls == 11'd0
            || (cls[0] && !(f7 == 7'h00 || (alt && (f3 == 3'b000 || f3 == 3'b101))))
            || (cls[1] && ((f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && !alt)))
            || (cls[4] && (f3 == 3'b010 || f3 == 3'b011))
            || (cls[2] && (f3 == 3'b011 || f3 >= 3'b110))
            || (cls[3] && f3 > 3'b010)
            || (cls[6] && f3 != 3'b000)
            || (sys0 && !(i12 == 12'h000 || i12 == 12'h001 || i12 == 12'h302));
  always_comb begin
    case (f3)
      3'd0: arith_op = cls[0] && alt ? SUB : ADD;
      3'd1: arith_op = SLL;
      3'd2: arith_op = SLT;
      3'd3: arith_op = SLTU;
      3'd4: arith_op = XOR;
      3'd5: arith_op = alt ? SRA : SRL;
      3'd6: arith_op = OR;
      default: arith_op = AND;
    endcase
    case (f3)
      3'd0: br_op = EQ;
      3'd1: br_op = NEQ;
      3'd4: br_op = SLT;
      3'd5: br_op = GE;
      3'd6: br_op = SLTU;
      3'd7: br_op = GEU;
      default: br_op = ADD;
    endcase
  end
  always_comb begin
    dec.rs1     = fetch_instr[19:15];
    dec.rs2     = fetch_instr[24:20];
    dec.rd      = (cls[3] || cls[4] || cls[10] || sys0) ? 5'd0 : fetch_instr[11:7];
    dec.imm     = (cls[1] || cls[2] || cls[6] || cls[9]) ? imm_i :
                  cls[3] ? imm_s : cls[4] ? imm_b : (cls[7] || cls[8]) ? imm_u :
                  cls[5] ? imm_j : 32'd0;
    dec.funct3  = f3;
    dec.alu_op  = (cls[0] || cls[1]) ? arith_op : cls[4] ? br_op : ADD;
    dec.cls     = bad ? 11'd0 : cls;
    dec.pc      = fetch_pc;
    dec.illegal = bad;
    dec.ecall   = trap_ok && i12 == 12'h000;
    dec.ebreak  = trap_ok && i12 == 12'h001;
    dec.mret    = trap_ok && i12 == 12'h302;
    dec_d         = (clk_en && !stall) ? dec : dec_q;
    next_clk_en_d = stall ? next_clk_en_q : !flush && clk_en;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q         <= '0;
      next_clk_en_q <= 1'b0;
    end else begin
      dec_q         <= dec_d;
      next_clk_en_q <= next_clk_en_d;
    end
  end
  assign rs1_addr_rf   = fetch_instr[19:15];
  assign rs2_addr_rf   = fetch_instr[24:20];
  assign rs1_addr      = dec_q.rs1;
  assign rs2_addr      = dec_q.rs2;
  assign rd_addr       = dec_q.rd;
  assign imm           = dec_q.imm;
  assign funct3        = dec_q.funct3;
  assign alu_op        = dec_q.alu_op;
  assign opcode_class  = dec_q.cls;
  assign pc            = dec_q.pc;
  assign illegal_instr = dec_q.illegal;
  assign ecall         = dec_q.ecall;
  assign ebreak        = dec_q.ebreak;
  assign mret          = dec_q.mret;
  assign next_clk_en   = next_clk_en_q;
  assign stall_out     = stall;
  assign flush_out     = flush;
endmodule

// File: tb/tb_decode.sv
// tb_decode: vector table, hand-written pipeline-control sequences and random stimulus
// checked against a behavioural RV32I decode model.
module tb_decode;
  logic        clk, rst, clk_en, stall, flush;
  logic [31:0] fetch_instr, fetch_pc;
  logic [4:0]  rs1_addr_rf, rs2_addr_rf, rs1_addr, rs2_addr, rd_addr;
  logic [31:0] imm, pc;
  logic [2:0]  funct3;
  logic [3:0]  alu_op;
  logic [10:0] opcode_class;
  logic        illegal_instr, ecall, ebreak, mret, stall_out, flush_out, next_clk_en;
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic [10:0] cls;
    logic        ill;
    logic        ec;
    logic        eb;
    logic        mr;
  } exp_t;
  typedef struct packed {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;
  vec_t        vt[16];
  exp_t        m;
  logic [31:0] m_pc;
  logic        m_nce;
  int          cmp_n = 0, bad_n = 0;
  decode dut (
    .clk(clk), .rst(rst), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .clk_en(clk_en),
    .rs1_addr_rf(rs1_addr_rf), .rs2_addr_rf(rs2_addr_rf), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rd_addr(rd_addr), .imm(imm), .funct3(funct3), .alu_op(alu_op),
    .opcode_class(opcode_class), .pc(pc), .illegal_instr(illegal_instr), .ecall(ecall),
    .ebreak(ebreak), .mret(mret), .stall(stall), .flush(flush), .stall_out(stall_out),
    .flush_out(flush_out), .next_clk_en(next_clk_en)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t              e;
    logic signed [31:0] s, t;
    logic [3:0]        arith[8];
    logic [3:0]        br[8];
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [11:0]       i12;
    int                c;
    arith = '{4'd0, 4'd7, 4'd2, 4'd3, 4'd4, 4'd8, 4'd5, 4'd6};
    br    = '{4'd10, 4'd11, 4'd0, 4'd0, 4'd2, 4'd12, 4'd3, 4'd13};
    s = w; f3 = w[14:12]; f7 = w[31:25]; i12 = w[31:20];
    e = '0; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.f3 = f3;
    c = -1;
    case (w[6:0])
      7'h33: begin
        c = 0;
        e.alu = (f7 == 7'h20 && f3 == 0) ? 4'd1 : (f7 == 7'h20 && f3 == 5) ? 4'd9 : arith[f3];
        e.ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
      end
      7'h13: begin
        c = 1; e.imm = s >>> 20;
        e.alu = (f3 == 5 && f7 == 7'h20) ? 4'd9 : arith[f3];
        e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
      end
      7'h03: begin c = 2; e.imm = s >>> 20; e.ill = f3 == 3 || f3 >= 6; end
      7'h23: begin
        c = 3; t = s >>> 25; e.imm = (t << 5) | {27'b0, w[11:7]}; e.ill = f3 > 2; e.rd = 0;
      end
      7'h63: begin
        c = 4; t = s >>> 31;
        e.imm = (t << 12) | {20'b0, w[7], w[30:25], w[11:8], 1'b0};
        e.alu = br[f3]; e.ill = f3 == 2 || f3 == 3; e.rd = 0;
      end
      7'h6F: begin
        c = 5; t = s >>> 31;
        e.imm = (t << 20) | {12'b0, w[19:12], w[20], w[30:21], 1'b0};
      end
      7'h67: begin c = 6; e.imm = s >>> 20; e.ill = f3 != 0; end
      7'h37: begin c = 7; e.imm = w & 32'hFFFF_F000; end
      7'h17: begin c = 8; e.imm = w & 32'hFFFF_F000; end
      7'h73: begin
        c = 9; e.imm = s >>> 20;
        if (f3 == 0) begin
          e.rd  = 0;
          e.ill = !(i12 inside {12'h000, 12'h001, 12'h302});
          e.ec  = i12 == 12'h000 && w[19:15] == 0 && w[11:7] == 0;
          e.eb  = i12 == 12'h001 && w[19:15] == 0 && w[11:7] == 0;
          e.mr  = i12 == 12'h302 && w[19:15] == 0 && w[11:7] == 0;
        end
      end
      7'h0F: begin c = 10; e.rd = 0; end
      default: e.ill = 1'b1;
    endcase
    e.cls = (c >= 0 && !e.ill) ? 11'(11'd1 << c) : 11'd0;
    return e;
  endfunction
  function automatic logic [31:0] gen();
    logic [6:0]  ops[11];
    logic [11:0] sys[3];
    logic [31:0] w;
    int          k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};
    sys = '{12'h000, 12'h001, 12'h302};
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 11) w[6:0] = ops[k];
    k = $urandom_range(0, 3);
    if (k == 0) w[31:25] = 7'h00;
    if (k == 1) w[31:25] = 7'h20;
    if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 1) begin
      w[31:20] = sys[$urandom_range(0, 2)];
      w[14:12] = 3'b000;
      if ($urandom_range(0, 3) != 0) begin w[19:15] = 5'd0; w[11:7] = 5'd0; end
    end
    return w;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic check_dut(input string tag, input exp_t e, input logic [31:0] epc, input logic enc);
    chk({tag, ".rs1"}, 32'(rs1_addr), 32'(e.rs1));
    chk({tag, ".rs2"}, 32'(rs2_addr), 32'(e.rs2));
    chk({tag, ".rd"}, 32'(rd_addr), 32'(e.rd));
    chk({tag, ".imm"}, imm, e.imm);
    chk({tag, ".funct3"}, 32'(funct3), 32'(e.f3));
    chk({tag, ".alu_op"}, 32'(alu_op), 32'(e.alu));
    chk({tag, ".class"}, 32'(opcode_class), 32'(e.cls));
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".traps"}, {28'b0, illegal_instr, ecall, ebreak, mret}, {28'b0, e.ill, e.ec, e.eb, e.mr});
    chk({tag, ".next_clk_en"}, 32'(next_clk_en), 32'(enc));
  endtask
  task automatic step();
    @(posedge clk);
    if (!stall && clk_en) begin m = ref_dec(fetch_instr); m_pc = fetch_pc; end
    m_nce = stall ? m_nce : (flush ? 1'b0 : clk_en);
    #1;
  endtask
  initial begin
    vt[0]  = '{32'hFFB10093, '{5'd2, 5'd27, 5'd1, 32'hFFFFFFFB, 3'd0, 4'd0, 11'h002, 1'b0, 1'b0, 1'b0, 1'b0}};
    vt[1]  = '{32'h402081B3, '{5'd1, 5'd2, 5'd3, 32'h0, 3'd0, 4'd1, 11'h001, 1'b0, 1'b0, 1'b0, 1'b0}};
    vt[2]  = '{32'h123452B7, '{5'd8, 5'd3, 5'd5, 32'h12345000, 3'd5, 4'd0, 11'h080, 1'b0, 1'b0, 1'b0, 1'b0}};
    vt[3]  = '{32'h00000000, '{5'd0, 5'd0, 5'd0, 32'h0, 3'd0, 4'd0, 11'h000, 1'b1, 1'b0, 1'b0, 1'b0}};
    vt[4]  = '{32'hFFFFFFFF, '{5'd31, 5'd31, 5'd31, 32'h0, 3'd7, 4'd0, 11'h000, 1'b1, 1'b0, 1'b0, 1'b0}};
    vt[5]  = '{32'h00000073, '{5'd0, 5'd0, 5'd0, 32'h0, 3'd0, 4'd0, 11'h200, 1'b0, 1'b1, 1'b0, 1'b0}};
    vt[6]  = '{32'h00100073, '{5'd0, 5'd1, 5'd0, 32'h1, 3'd0, 4'd0, 11'h200, 1'b0, 1'b0, 1'b1, 1'b0}};
    vt[7]  = '{32'h30200073, '{5'd0, 5'd2, 5'd0, 32'h302, 3'd0, 4'd0, 11'h200, 1'b0, 1'b0, 1'b0, 1'b1}};
    vt[8]  = '{32'h40315093, '{5'd2, 5'd3, 5'd1, 32'h403, 3'd5, 4'd9, 11'h002, 1'b0, 1'b0, 1'b0, 1'b0}};
    vt[9]  = '{32'hFE208EE3, '{5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 3'd0, 4'd10, 11'h010, 1'b0, 1'b0, 1'b0, 1'b0}};
    vt[10] = '{32'h0020A423, '{5'd1, 5'd2, 5'd0, 32'h8, 3'd2, 4'd0, 11'h008, 1'b0, 1'b0, 1'b0, 1'b0}};
    vt[11] = '{32'h001000EF, '{5'd0, 5'd1, 5'd1, 32'h800, 3'd0, 4'd0, 11'h020, 1'b0, 1'b0, 1'b0, 1'b0}};
    vt[12] = '{32'h402091B3, '{5'd1, 5'd2, 5'd3, 32'h0, 3'd1, 4'd7, 11'h000, 1'b1, 1'b0, 1'b0, 1'b0}};
    vt[13] = '{32'hFE20EEE3, '{5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 3'd6, 4'd3, 11'h010, 1'b0, 1'b0, 1'b0, 1'b0}};
    vt[14] = '{32'h00013083, '{5'd2, 5'd0, 5'd1, 32'h0, 3'd3, 4'd0, 11'h000, 1'b1, 1'b0, 1'b0, 1'b0}};
    vt[15] = '{32'h000000F3, '{5'd0, 5'd0, 5'd0, 32'h0, 3'd0, 4'd0, 11'h200, 1'b0, 1'b0, 1'b0, 1'b0}};
    rst = 1'b1; clk_en = 1'b0; stall = 1'b0; flush = 1'b0; fetch_instr = '0; fetch_pc = '0;
    m = '0; m_pc = '0; m_nce = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_dut("reset", '0, 32'h0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      fetch_instr = vt[k].instr; fetch_pc = 32'h1000 + 32'(4 * k); clk_en = 1'b1;
      #1;
      chk($sformatf("vec%0d.rs1_rf", k), 32'(rs1_addr_rf), 32'(vt[k].e.rs1));
      chk($sformatf("vec%0d.rs2_rf", k), 32'(rs2_addr_rf), 32'(vt[k].e.rs2));
      step();
      check_dut($sformatf("vec%0d", k), vt[k].e, 32'h1000 + 32'(4 * k), 1'b1);
    end
    fetch_instr = 32'hFFB10093; fetch_pc = 32'h2000;
    step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fetch_instr = 32'h402081B3 + 32'(k << 7); fetch_pc = $urandom;
      step();
      chk("stall.rd", 32'(rd_addr), 32'd1);
      chk("stall.imm", imm, 32'hFFFFFFFB);
      chk("stall.class", 32'(opcode_class), 32'h002);
      chk("stall.pc", pc, 32'h2000);
      chk("stall.next_clk_en", 32'(next_clk_en), 32'd1);
      chk("stall.stall_out", 32'(stall_out), 32'd1);
    end
    stall = 1'b0; fetch_instr = 32'h402081B3;
    step();
    chk("unstall.alu_op", 32'(alu_op), 32'd1);
    flush = 1'b1;
    step();
    chk("flush.next_clk_en", 32'(next_clk_en), 32'd0);
    chk("flush.flush_out", 32'(flush_out), 32'd1);
    flush = 1'b0;
    step();
    chk("post_flush.next_clk_en", 32'(next_clk_en), 32'd1);
    flush = 1'b1; stall = 1'b1;
    step();
    chk("stall_flush1.next_clk_en", 32'(next_clk_en), 32'd1);
    step();
    chk("stall_flush2.next_clk_en", 32'(next_clk_en), 32'd1);
    stall = 1'b0;
    step();
    chk("flush_after_stall.next_clk_en", 32'(next_clk_en), 32'd0);
    flush = 1'b0;
    step();
    chk("bubble_pre.next_clk_en", 32'(next_clk_en), 32'd1);
    clk_en = 1'b0; fetch_instr = 32'h123452B7;
    step();
    check_dut("bubble", m, m_pc, 1'b0);
    chk("bubble.rd_hold", 32'(rd_addr), 32'd3);
    clk_en = 1'b1;
    step();
    chk("bubble_post.next_clk_en", 32'(next_clk_en), 32'd1);
    chk("bubble_post.imm", imm, 32'h12345000);
    #2;
    rst = 1'b1;
    #1;
    m = '0; m_pc = '0; m_nce = 1'b0;
    check_dut("async_rst", '0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0; clk_en = 1'b0;
    step();
    chk("rst_then_idle.next_clk_en", 32'(next_clk_en), 32'd0);
    clk_en = 1'b1;
    step();
    chk("rst_then_en.next_clk_en", 32'(next_clk_en), 32'd1);
    for (int k = 0; k < 600; k++) begin
      fetch_instr = gen(); fetch_pc = $urandom;
      clk_en = $urandom_range(0, 3) != 0;
      stall  = $urandom_range(0, 6) == 0;
      flush  = $urandom_range(0, 9) == 0;
      step();
      check_dut($sformatf("rnd%0d", k), m, m_pc, m_nce);
      chk($sformatf("rnd%0d.stall_out", k), 32'(stall_out), 32'(stall));
      chk($sformatf("rnd%0d.flush_out", k), 32'(flush_out), 32'(flush));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end
endmodule

// File: doc/decode.md
# decode

Stage 2 of the RV32I five-stage pipeline. It sits directly downstream of the fetch stage and consumes the fetched instruction word, its PC and fetch's clock-enable. It splits the instruction into register addresses, a sign-extended immediate, an ALU operation code, a one-hot instruction class and trap flags, and registers them for the execute stage. It propagates the pipeline clock-enable/stall/flush protocol so bubbles and flushes travel down the pipe one stage per cycle.

## Interface
- No parameters.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- fetch_instr  in  32  instruction word from fetch.
- fetch_pc  in  32  PC of fetch_instr.
- clk_en  in  1  stage enable; driven by fetch's next_clk_en.
- rs1_addr_rf, rs2_addr_rf  out  5  combinational fetch_instr[19:15] and fetch_instr[24:20], to the register-file read ports.
- rs1_addr, rs2_addr, rd_addr  out  5  registered register addresses.
- imm  out  32  registered sign-extended immediate.
- funct3  out  3  registered instr[14:12].
- alu_op  out  4  registered ALU code: ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4, OR=5, AND=6, SLL=7, SRL=8, SRA=9, EQ=10, NEQ=11, GE=12, GEU=13.
- opcode_class  out  11  registered one-hot, bit0..10 = R, OPIMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, FENCE.
- pc  out  32  registered PC of the decoded instruction.
- illegal_instr, ecall, ebreak, mret  out  1  registered trap flags.
- stall  in  1  stall request from later stages.
- flush  in  1  flush request from later stages.
- stall_out  out  1  stall request to fetch.
- flush_out  out  1  flush request to fetch.
- next_clk_en  out  1  enable for the execute stage.

## Operation
- Decoding is combinational on fetch_instr. The result is captured into the output registers.
- Immediates:
  - I-type (OPIMM, LOAD, JALR, SYSTEM): sext(instr[31:20]).
  - S-type: sext({[31:25],[11:7]}).
  - B-type: sext({[31],[7],[30:25],[11:8],0}).
  - U-type (LUI, AUIPC): {[31:12],12'b0}.
  - J-type: sext({[31],[19:12],[20],[30:21],0}).
  - R and FENCE: 0.
- alu_op for R and OPIMM comes from funct3:
  - 000: ADD, or SUB when R with funct7=0x20.
  - 001: SLL; 010: SLT; 011: SLTU; 100: XOR.
  - 101: SRL, or SRA when funct7=0x20 (R and OPIMM).
  - 110: OR; 111: AND.
  - OPIMM never yields SUB.
- alu_op for BRANCH: BEQ→EQ, BNE→NEQ, BLT→SLT, BGE→GE, BLTU→SLTU, BGEU→GEU.
- alu_op for all other classes: ADD.
- rd_addr is forced to 0 for STORE, BRANCH and FENCE, and for SYSTEM with funct3=000.
- illegal_instr=1 when any of the following holds:
  - instr[1:0]≠11 or the opcode is unknown.
  - R with funct7∉{0x00,0x20}, or funct7=0x20 with funct3∉{000,101}.
  - OPIMM shift with a bad funct7.
  - BRANCH funct3∈{010,011}.
  - LOAD funct3∈{011,110,111}; STORE funct3>010.
  - JALR funct3≠000.
  - SYSTEM funct3=000 with instr[31:20]∉{0x000,0x001,0x302}.
- When illegal_instr=1, opcode_class is forced to 0.
- ecall/ebreak/mret assert for SYSTEM funct3=000 with instr[31:20] = 0x000 / 0x001 / 0x302 respectively, and rs1=rd=0.

## Timing
- Reset: all registered outputs and next_clk_en are 0 (alu_op=ADD, opcode_class=0).
- Latency: one cycle, fetch_instr → registered outputs.
- Register update: at posedge when clk_en=1 and stall=0. Otherwise all decoded registers hold.
- next_clk_en, evaluated at posedge in priority order:
  1. stall=1: hold.
  2. flush=1: ←0.
  3. otherwise: ←clk_en.
- stall_out = stall and flush_out = flush, both combinational. Decode never self-stalls.
- Simultaneous stall and flush: stall wins. The flush takes effect on the first cycle stall is low, provided flush is still high.
- clk_en=0 with stall=0: outputs hold and next_clk_en←0 (a bubble propagates).
- Reset mid-operation clears everything asynchronously. next_clk_en stays 0 until a cycle where clk_en=1.

## Test plan
- ADDI x1,x2,-5 (0xFFB10093), clk_en=1 → next cycle:
  - rd_addr=1, rs1_addr=2, imm=0xFFFFFFFB, alu_op=0, opcode_class=0x002, next_clk_en=1.
- SUB x3,x1,x2 (0x402081B3) → alu_op=1, opcode_class=0x001, rs2_addr=2, imm=0.
- LUI x5,0x12345 (0x123452B7) → imm=0x12345000, opcode_class=0x080, rd_addr=5.
- Instructions 0x00000000 and 0xFFFFFFFF → illegal_instr=1, opcode_class=0.
- ECALL (0x00000073) → ecall=1, rd_addr=0.
- Stall: ADDI latched, then stall=1 for 3 cycles while fetch_instr changes → outputs and next_clk_en unchanged; stall_out=1 throughout.
- Flush:
  - flush=1, stall=0 → next_clk_en=0 next cycle.
  - flush=1 and stall=1 together → next_clk_en held until stall drops.
- Bubble and reset:
  - clk_en=0 for one cycle → next_clk_en=0 for exactly one cycle.
  - Async rst pulse mid-stream → all outputs 0 immediately.
